uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Command sequencer between the UART receiver, the ALU and the UART transmitter. Collects three received bytes (operand A, operand B, opcode), holds them as stable ALU inputs, and hands the ALU result to the transmitter with a single start pulse. It is the only block that drives ALU operands, and it owns the transmit request.

## Interface
- DBIT, 8, ALU operand/result width (1..8); the low DBIT bits of each received byte are used.
- OP_LEN, 6, opcode width; the low OP_LEN bits of the opcode byte are used.
- TIMEOUT_TICKS, 1600, inter-byte timeout in baud-tick units; only used with the timeout feature.
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_done_tick  in  1  one-cycle pulse: i_rx_data is valid.
- i_rx_data  in  8  received byte.
- i_s_tick  in  1  16x baud tick (timeout timebase).
- i_alu_result  in  DBIT  combinational ALU result.
- i_tx_done_tick  in  1  one-cycle pulse: transmitter finished its frame.
- o_data_a  out  DBIT  ALU operand A.
- o_data_b  out  DBIT  ALU operand B.
- o_op  out  OP_LEN  ALU opcode.
- o_tx_start  out  1  one-cycle transmit request.
- o_tx_data  out  8  byte to transmit: result, zero-extended.
- o_busy  out  1  high in SEND and WAIT_TX.
- o_overrun  out  1  one-cycle pulse: a byte arrived while busy and was dropped.
- o_timeout  out  1  one-cycle pulse: partial command abandoned.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX. Reset state: WAIT_A.
- WAIT_A + i_rx_done_tick: o_data_a <= byte, go to WAIT_B.
- WAIT_B + i_rx_done_tick: o_data_b <= byte, go to WAIT_OP.
- WAIT_OP + i_rx_done_tick: o_op <= byte, go to SEND.
- SEND: unconditional, one cycle. o_tx_data <= i_alu_result and o_tx_start <= 1. Go to WAIT_TX.
- WAIT_TX + i_tx_done_tick: go to WAIT_A. Without i_tx_done_tick, stay indefinitely.
- An i_rx_done_tick in SEND or WAIT_TX:
  - the byte is discarded;
  - o_overrun pulses on the next cycle;
  - o_data_a, o_data_b and o_op are unchanged.
- o_data_a, o_data_b and o_op hold their values until overwritten. The ALU inputs stay stable through the whole transmit.
- An i_tx_done_tick outside WAIT_TX is ignored.
- An i_s_tick is ignored when the timeout feature is compiled out.
- Reset values: o_data_a=0, o_data_b=0, o_op=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_overrun=0, o_timeout=0.
- Reset assertion mid-command returns to WAIT_A immediately and clears all outputs. Any partially collected command is lost.

## Timing
- All outputs are registered; no combinational path from input to output.
- Opcode byte with i_rx_done_tick in cycle N:
  - o_op is valid and the state is SEND in cycle N+1;
  - o_tx_start is high and o_tx_data is valid in cycle N+2 only.
- i_alu_result must settle within one cycle of o_op changing; it is sampled at the end of cycle N+1.
- i_tx_done_tick in cycle M: the state is WAIT_A in cycle M+1. A byte arriving in cycle M+1 is accepted.
- o_busy is high in cycles N+1 through M.

## Configuration
- UART_ALU_CTRL_TIMEOUT_EN defined:
  - in WAIT_B and WAIT_OP, a counter increments on each i_s_tick;
  - the counter clears on every accepted byte and on entry to WAIT_A;
  - when it reaches TIMEOUT_TICKS-1 with i_s_tick high, the block returns to WAIT_A and o_timeout pulses next cycle;
  - already captured operands are not cleared;
  - an i_rx_done_tick in the same cycle as the expiry wins: the byte is accepted and the counter cleared.
- UART_ALU_CTRL_TIMEOUT_EN undefined: no counter, o_timeout is tied 0, and WAIT_B/WAIT_OP wait indefinitely.

## Structure
- Shared package uart_pkg holds:
  - the state encoding localparams for this block;
  - the default baud-tick constants (16 ticks per bit, 10 bits per frame).
- Timeout counter is sub-module uart_timeout_cnt:
  - ports: clear, tick, expire;
  - counter width is $clog2(TIMEOUT_TICKS);
  - instantiated only under the macro.

## Test plan
- Reset with all inputs toggling -> every output 0 and state WAIT_A. Release, then bytes 0x05, 0x03, 0x20 -> o_data_a=5, o_data_b=3, o_op=0x20, o_tx_start pulses exactly once, 2 cycles after the opcode tick.
- Model ALU as add: bytes 0xF0, 0x20, 0x20 -> o_tx_data=0x10 while o_tx_start is high. After i_tx_done_tick, next command 0x01, 0x01, 0x20 -> o_tx_data=0x02.
- Byte 0x77 while in WAIT_TX -> o_overrun pulses once, operands unchanged, no extra o_tx_start.
- Back-to-back: i_tx_done_tick in cycle M, byte 0x09 in cycle M+1 -> o_data_a=0x09.
- Reset asserted in WAIT_OP -> outputs clear. After release, a three-byte command completes normally.
- Macro on, TIMEOUT_TICKS=32: byte 0x05, then 32 i_s_tick pulses -> o_timeout pulses once and state WAIT_A. Separately, a byte on the 32nd tick -> accepted, no timeout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-tick timebase constants and the command sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Default baud timebase: 16 oversampling ticks per bit, 10-bit frame (start + 8 data + stop).
    localparam int unsigned TICKS_PER_BIT  = 16;
    localparam int unsigned BITS_PER_FRAME = 10;
    localparam int unsigned FRAME_TICKS    = TICKS_PER_BIT * BITS_PER_FRAME;

    // Command sequencer state encoding.
    localparam logic [2:0] CTRL_WAIT_A  = 3'd0;
    localparam logic [2:0] CTRL_WAIT_B  = 3'd1;
    localparam logic [2:0] CTRL_WAIT_OP = 3'd2;
    localparam logic [2:0] CTRL_SEND    = 3'd3;
    localparam logic [2:0] CTRL_WAIT_TX = 3'd4;

    typedef enum logic [2:0] {
        ST_WAIT_A  = CTRL_WAIT_A,
        ST_WAIT_B  = CTRL_WAIT_B,
        ST_WAIT_OP = CTRL_WAIT_OP,
        ST_SEND    = CTRL_SEND,
        ST_WAIT_TX = CTRL_WAIT_TX
    } ctrl_state_e;

    // The sequencer refuses new bytes while a result is being handed to, or sent by, the transmitter.
    function automatic logic ctrl_is_busy(input ctrl_state_e s);
        return (s == ST_SEND) || (s == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: counts qualified ticks, flags the tick that completes TIMEOUT_TICKS.
// Latency: expire is combinational on the final tick; the count clears on the following edge.
// Backpressure: none; clear has priority over counting.
module uart_timeout_cnt #(
    parameter int unsigned TIMEOUT_TICKS = 1600
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

    logic [CW-1:0] cnt_q;

    assign expire = tick && (cnt_q == LAST);

    // Tick counter: restarts on clear or on expiry, otherwise advances one per tick.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else if (clear || expire) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer: collects A, B, opcode bytes from the UART RX, drives stable ALU operands, hands the result to the UART TX.
// Latency: opcode tick in cycle N -> o_op in N+1, o_tx_start/o_tx_data in N+2; all outputs registered.
// Backpressure: bytes arriving while busy are dropped and flagged on o_overrun; optional inter-byte timeout via UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DBIT          = 8,
    parameter int unsigned OP_LEN        = 6,
    parameter int unsigned TIMEOUT_TICKS = 1600
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_done_tick,
    input  logic [7:0]        i_rx_data,
    input  logic              i_s_tick,
    input  logic [DBIT-1:0]   i_alu_result,
    input  logic              i_tx_done_tick,
    output logic [DBIT-1:0]   o_data_a,
    output logic [DBIT-1:0]   o_data_b,
    output logic [OP_LEN-1:0] o_op,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_timeout
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic ld_a;
    logic ld_b;
    logic ld_op;
    logic overrun_d;
    logic timeout_d;
    logic tmo_expire;

    // Upper received bits beyond the operand/opcode widths are intentionally ignored.
    logic [7:0] unused_rx;
    assign unused_rx = i_rx_data;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    logic tmo_counting;

    // Only a partially collected command can time out; everywhere else the counter is held clear.
    assign tmo_counting = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

    uart_timeout_cnt #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clear   (!tmo_counting || i_rx_done_tick),
        .tick    (tmo_counting && i_s_tick),
        .expire  (tmo_expire)
    );

    // Abandoned-command pulse, one cycle after expiry.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_d;
        end
    end
`else
    localparam int unsigned unused_tmo_ticks = TIMEOUT_TICKS;
    logic unused_tmo;

    assign tmo_expire = 1'b0;
    assign unused_tmo = i_s_tick ^ timeout_d;
    assign o_timeout  = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture strobes; a received byte always beats a simultaneous timeout.
    always_comb begin
        state_d   = state_q;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done_tick) begin
                    ld_a    = 1'b1;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done_tick) begin
                    ld_b    = 1'b1;
                    state_d = ST_WAIT_OP;
                end else if (tmo_expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done_tick) begin
                    ld_op   = 1'b1;
                    state_d = ST_SEND;
                end else if (tmo_expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end
            end
            ST_SEND: begin
                overrun_d = i_rx_done_tick;
                state_d   = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                overrun_d = i_rx_done_tick;
                if (i_tx_done_tick) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    // Operand/opcode holding registers and the transmit handoff; ALU inputs stay put until the next command overwrites them.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            if (ld_a) begin
                o_data_a <= i_rx_data[DBIT-1:0];
            end
            if (ld_b) begin
                o_data_b <= i_rx_data[DBIT-1:0];
            end
            if (ld_op) begin
                o_op <= i_rx_data[OP_LEN-1:0];
            end
            o_tx_start <= (state_q == ST_SEND);
            if (state_q == ST_SEND) begin
                o_tx_data <= 8'(i_alu_result);
            end
            o_busy    <= ctrl_is_busy(state_d);
            o_overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;
    import uart_pkg::*;

    localparam int DBIT   = 8;
    localparam int OP_LEN = 6;
    localparam int TT     = 32;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        rx_done  = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        s_tick   = 1'b0;
    logic        tx_done  = 1'b0;
    logic [7:0]  alu_result;
    logic [7:0]  data_a;
    logic [7:0]  data_b;
    logic [5:0]  op;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // ALU stand-in: 8-bit add.
    assign alu_result = data_a + data_b;

    uart_alu_ctrl #(
        .DBIT(DBIT), .OP_LEN(OP_LEN), .TIMEOUT_TICKS(TT)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_rx_done_tick (rx_done),
        .i_rx_data      (rx_data),
        .i_s_tick       (s_tick),
        .i_alu_result   (alu_result),
        .i_tx_done_tick (tx_done),
        .o_data_a       (data_a),
        .o_data_b       (data_b),
        .o_op           (op),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_busy         (busy),
        .o_overrun      (overrun),
        .o_timeout      (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A command is a list of received bytes; once three are in, a result is owed to the
    // transmitter (send_pending), then a frame is in flight until tx_done.
    logic [7:0] m_a = 0, m_b = 0, m_txd = 0;
    logic [5:0] m_op = 0;
    bit m_start = 0, m_busy = 0, m_over = 0, m_tmo = 0;
    logic [7:0] cmd[$];
    bit send_pending = 0, in_flight = 0, was_busy = 0;
    int idle_ticks = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_op = 0; m_txd = 0;
            m_start = 0; m_busy = 0; m_over = 0; m_tmo = 0;
            cmd.delete(); send_pending = 0; in_flight = 0; idle_ticks = 0;
        end else begin
            was_busy = send_pending || in_flight;
            m_start = 0; m_over = 0; m_tmo = 0;
            if (send_pending) begin
                m_txd = m_a + m_b;
                m_start = 1;
                send_pending = 0;
                in_flight = 1;
            end else if (in_flight && tx_done) begin
                in_flight = 0;
            end
            if (rx_done) begin
                if (was_busy) m_over = 1;
                else begin
                    cmd.push_back(rx_data);
                    idle_ticks = 0;
                    if (cmd.size() == 1) m_a = rx_data;
                    else if (cmd.size() == 2) m_b = rx_data;
                    else begin
                        m_op = rx_data[5:0];
                        send_pending = 1;
                        cmd.delete();
                    end
                end
            end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
            else if (cmd.size() > 0 && s_tick) begin
                if (idle_ticks == TT - 1) begin
                    m_tmo = 1;
                    cmd.delete();
                    idle_ticks = 0;
                end else begin
                    idle_ticks++;
                end
            end
`endif
            m_busy = send_pending || in_flight;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("data_a", 32'(data_a), 32'(m_a));
        check("data_b", 32'(data_b), 32'(m_b));
        check("op", 32'(op), 32'(m_op));
        check("tx_start", 32'(tx_start), 32'(m_start));
        check("tx_data", 32'(tx_data), 32'(m_txd));
        check("busy", 32'(busy), 32'(m_busy));
        check("overrun", 32'(overrun), 32'(m_over));
        check("timeout", 32'(timeout), 32'(m_tmo));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        step();
        rx_data = b; rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        step(); tx_done = 1'b1;
        step(); tx_done = 1'b0;
    endtask

    task automatic pulse_s_tick();
        step(); s_tick = 1'b1;
        step(); s_tick = 1'b0;
    endtask

    // Sends a full command and pins the handoff timing with literal expectations.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                           input logic [7:0] exp_res);
        send_byte(a);
        send_byte(b);
        send_byte(o);
        check("cmd_a", 32'(data_a), 32'(a));
        check("cmd_b", 32'(data_b), 32'(b));
        check("cmd_op", 32'(op), 32'(o[5:0]));
        check("start_n1", 32'(tx_start), 32'd0);
        check("busy_n1", 32'(busy), 32'd1);
        step();
        check("start_n2", 32'(tx_start), 32'd1);
        check("txdata_n2", 32'(tx_data), 32'(exp_res));
        step();
        check("start_n3", 32'(tx_start), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            step();
            rx_done = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom_range(0, 255));
            s_tick  = 1'($urandom_range(0, 1));
            tx_done = 1'($urandom_range(0, 1));
            check("rst_a", 32'(data_a), 32'd0);
            check("rst_start", 32'(tx_start), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_state", 32'(dut.state_q), 32'(ST_WAIT_A));
        end
        step();
        rx_done = 0; rx_data = 0; s_tick = 0; tx_done = 0;
        rst_n = 1'b1;

        // First command 5,3,0x20 -> 8.
        run_cmd(8'h05, 8'h03, 8'h20, 8'h08);
        repeat (3) step();
        // Byte while waiting for TX: dropped, flagged, operands untouched.
        send_byte(8'h77);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_a", 32'(data_a), 32'h05);
        check("ovr_b", 32'(data_b), 32'h03);
        check("ovr_nostart", 32'(tx_start), 32'd0);
        step();
        check("ovr_once", 32'(overrun), 32'd0);
        pulse_tx_done();
        check("idle_busy", 32'(busy), 32'd0);

        // Stray tx_done in WAIT_A is ignored.
        pulse_tx_done();

        // Wrapping add and a second command.
        run_cmd(8'hF0, 8'h20, 8'h20, 8'h10);
        pulse_tx_done();
        run_cmd(8'h01, 8'h01, 8'h20, 8'h02);

        // Back-to-back: tx_done in M, new byte in M+1.
        step(); tx_done = 1'b1;
        step(); tx_done = 1'b0; rx_data = 8'h09; rx_done = 1'b1;
        step(); rx_done = 1'b0;
        check("b2b_a", 32'(data_a), 32'h09);
        send_byte(8'h01);
        send_byte(8'h20);
        step();
        check("b2b_res", 32'(tx_data), 32'h0A);
        pulse_tx_done();

        // Reset in WAIT_OP.
        send_byte(8'h11);
        send_byte(8'h22);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", 32'(data_a), 32'd0);
        check("mid_rst_b", 32'(data_b), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_WAIT_A));
        step(); step();
        rst_n = 1'b1;
        run_cmd(8'h04, 8'h06, 8'h20, 8'h0A);
        pulse_tx_done();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // Partial command abandoned after TT ticks.
        send_byte(8'h05);
        repeat (TT - 1) pulse_s_tick();
        check("tmo_early", 32'(timeout), 32'd0);
        pulse_s_tick();
        check("tmo_pulse", 32'(timeout), 32'd1);
        check("tmo_state", 32'(dut.state_q), 32'(ST_WAIT_A));
        check("tmo_keep_a", 32'(data_a), 32'h05);
        step();
        check("tmo_once", 32'(timeout), 32'd0);

        // Byte on the expiring tick wins.
        send_byte(8'h05);
        repeat (TT - 1) pulse_s_tick();
        step();
        s_tick = 1'b1; rx_data = 8'h07; rx_done = 1'b1;
        step();
        s_tick = 1'b0; rx_done = 1'b0;
        check("race_b", 32'(data_b), 32'h07);
        check("race_notmo", 32'(timeout), 32'd0);
        check("race_state", 32'(dut.state_q), 32'(ST_WAIT_OP));
        send_byte(8'h20);
        step();
        check("race_res", 32'(tx_data), 32'h0C);
        pulse_tx_done();
`else
        // Without the timeout feature, ticks never abandon a partial command.
        send_byte(8'h05);
        repeat (TT + 8) pulse_s_tick();
        check("notmo_state", 32'(dut.state_q), 32'(ST_WAIT_B));
        check("notmo_flag", 32'(timeout), 32'd0);
        send_byte(8'h07);
        send_byte(8'h20);
        step();
        check("notmo_res", 32'(tx_data), 32'h0C);
        pulse_tx_done();
`endif
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
